// File: rtl/spi_tap_engine.sv
// Bus-side SPI tap: synchronizes the real SPI lines and deserializes both data lines.
// It hands each word pair to the MITM logic and splices the returned fake words into the next word.
module spi_tap_engine #(
  parameter int DATA_SIZE   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 bus_sclk_in,
  input  logic                 bus_cs_n_in,
  input  logic                 bus_mosi_in,
  input  logic                 bus_miso_in,
  output logic                 bus_mosi_out,
  output logic                 bus_miso_out,
  output logic                 eval,
  input  logic                 done_sig,
  output logic [DATA_SIZE-1:0] real_mosi_data,
  output logic [DATA_SIZE-1:0] real_miso_data,
  input  logic [DATA_SIZE-1:0] fake_mosi_data,
  input  logic [DATA_SIZE-1:0] fake_miso_data,
  input  logic                 fake_mosi_select,
  input  logic                 fake_miso_select,
  output logic                 overrun_err
);

  // Handshake FSM
  //   state   | meaning
  //   ST_IDLE | no request outstanding; waits for an eval pulse
  //   ST_ACK  | request issued; waits for done_sig to drop
  //   ST_BUSY | logic working; waits for done_sig to rise, then latches the result

  localparam int               CNT_W    = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_BUSY
  } hs_state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] miso_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  logic sclk_s, cs_s, mosi_s, miso_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, boundary;

  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0] rx_mosi_q, rx_mosi_d;
  logic [DATA_SIZE-1:0] rx_miso_q, rx_miso_d;
  logic [DATA_SIZE-1:0] real_mosi_q, real_mosi_d;
  logic [DATA_SIZE-1:0] real_miso_q, real_miso_d;
  logic [DATA_SIZE-1:0] tx_mosi_q, tx_mosi_d;
  logic [DATA_SIZE-1:0] tx_miso_q, tx_miso_d;
  logic                 sel_mosi_q, sel_mosi_d;
  logic                 sel_miso_q, sel_miso_d;
  logic                 eval_q, eval_d;
  logic                 word_done_q, word_done_d;

  hs_state_e            state_q;
  logic [DATA_SIZE-1:0] pend_mosi_q;
  logic [DATA_SIZE-1:0] pend_miso_q;
  logic                 pend_sel_mosi_q;
  logic                 pend_sel_miso_q;
  logic                 pend_valid_q;
  logic                 stale_q;
  logic                 overrun_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      miso_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus_sclk_in};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus_cs_n_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus_mosi_in};
      miso_sync_q <= {miso_sync_q[SYNC_STAGES-2:0], bus_miso_in};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign miso_s = miso_sync_q[SYNC_STAGES-1];

  // SCLK activity only counts while the synchronized chip select is low.
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign boundary  = sclk_fall & word_done_q;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_mosi_d   = rx_mosi_q;
    rx_miso_d   = rx_miso_q;
    real_mosi_d = real_mosi_q;
    real_miso_d = real_miso_q;
    tx_mosi_d   = tx_mosi_q;
    tx_miso_d   = tx_miso_q;
    sel_mosi_d  = sel_mosi_q;
    sel_miso_d  = sel_miso_q;
    eval_d      = 1'b0;
    word_done_d = word_done_q;

    if (cs_rise) begin
      bit_cnt_d   = '0;
      rx_mosi_d   = '0;
      rx_miso_d   = '0;
      sel_mosi_d  = 1'b0;
      sel_miso_d  = 1'b0;
      word_done_d = 1'b0;
    end else begin
      if (cs_fall) begin
        sel_mosi_d  = 1'b0;
        sel_miso_d  = 1'b0;
        word_done_d = 1'b0;
      end

      if (sclk_rise) begin
        rx_mosi_d = {rx_mosi_q[DATA_SIZE-2:0], mosi_s};
        rx_miso_d = {rx_miso_q[DATA_SIZE-2:0], miso_s};
        if (bit_cnt_q == LAST_BIT) begin
          real_mosi_d = rx_mosi_d;
          real_miso_d = rx_miso_d;
          eval_d      = 1'b1;
          bit_cnt_d   = '0;
          word_done_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      // The fall after a completed word is where the next word's MSB goes out.
      if (sclk_fall) begin
        if (word_done_q) begin
          word_done_d = 1'b0;
          if (pend_valid_q) begin
            tx_mosi_d  = pend_mosi_q;
            tx_miso_d  = pend_miso_q;
            sel_mosi_d = pend_sel_mosi_q;
            sel_miso_d = pend_sel_miso_q;
          end else begin
            sel_mosi_d = 1'b0;
            sel_miso_d = 1'b0;
          end
        end else begin
          tx_mosi_d = {tx_mosi_q[DATA_SIZE-2:0], 1'b0};
          tx_miso_d = {tx_miso_q[DATA_SIZE-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      rx_mosi_q   <= '0;
      rx_miso_q   <= '0;
      real_mosi_q <= '0;
      real_miso_q <= '0;
      tx_mosi_q   <= '0;
      tx_miso_q   <= '0;
      sel_mosi_q  <= 1'b0;
      sel_miso_q  <= 1'b0;
      eval_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_mosi_q   <= rx_mosi_d;
      rx_miso_q   <= rx_miso_d;
      real_mosi_q <= real_mosi_d;
      real_miso_q <= real_miso_d;
      tx_mosi_q   <= tx_mosi_d;
      tx_miso_q   <= tx_miso_d;
      sel_mosi_q  <= sel_mosi_d;
      sel_miso_q  <= sel_miso_d;
      eval_q      <= eval_d;
      word_done_q <= word_done_d;
    end
  end

  // stale_q marks a handshake whose result must be thrown away (CS_N ended or boundary missed).
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      pend_mosi_q     <= '0;
      pend_miso_q     <= '0;
      pend_sel_mosi_q <= 1'b0;
      pend_sel_miso_q <= 1'b0;
      pend_valid_q    <= 1'b0;
      stale_q         <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (eval_q) begin
            state_q <= ST_ACK;
            stale_q <= 1'b0;
          end
        end
        ST_ACK: begin
          if (!done_sig) state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          if (done_sig) begin
            state_q <= ST_IDLE;
            if (!stale_q) begin
              pend_mosi_q     <= fake_mosi_data;
              pend_miso_q     <= fake_miso_data;
              pend_sel_mosi_q <= fake_mosi_select;
              pend_sel_miso_q <= fake_miso_select;
              pend_valid_q    <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (boundary) begin
        pend_valid_q <= 1'b0;
        if (!pend_valid_q && (state_q != ST_IDLE)) begin
          overrun_q <= 1'b1;
          stale_q   <= 1'b1;
        end
      end

      if (cs_rise) begin
        pend_valid_q <= 1'b0;
        if ((state_q != ST_IDLE) || eval_q) stale_q <= 1'b1;
      end
    end
  end

  // Forwarded bits bypass every flop so an unmodified word sees no added delay.
  assign bus_mosi_out   = sel_mosi_q ? tx_mosi_q[DATA_SIZE-1] : bus_mosi_in;
  assign bus_miso_out   = sel_miso_q ? tx_miso_q[DATA_SIZE-1] : bus_miso_in;
  assign eval           = eval_q;
  assign real_mosi_data = real_mosi_q;
  assign real_miso_data = real_miso_q;
  assign overrun_err    = overrun_q;

endmodule

// File: tb/tb_spi_tap_engine.sv
// Bench for spi_tap_engine: drives mode-0 SPI words, models the MITM logic handshake
// and scores eval words plus the bitwise forwarded/replaced bus outputs.
module tb_spi_tap_engine;
  localparam int DW   = 8;
  localparam int SS   = 2;
  localparam int HALF = 10;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bus_sclk_in = 1'b0;
  logic          bus_cs_n_in = 1'b1;
  logic          bus_mosi_in = 1'b0;
  logic          bus_miso_in = 1'b0;
  logic          bus_mosi_out, bus_miso_out, eval, overrun_err;
  logic          done_sig = 1'b1;
  logic [DW-1:0] real_mosi_data, real_miso_data;
  logic [DW-1:0] fake_mosi_data = '0;
  logic [DW-1:0] fake_miso_data = '0;
  logic          fake_mosi_select = 1'b0;
  logic          fake_miso_select = 1'b0;

  spi_tap_engine #(.DATA_SIZE(DW), .SYNC_STAGES(SS)) dut (
    .sys_clk         (sys_clk),
    .rst_n           (rst_n),
    .bus_sclk_in     (bus_sclk_in),
    .bus_cs_n_in     (bus_cs_n_in),
    .bus_mosi_in     (bus_mosi_in),
    .bus_miso_in     (bus_miso_in),
    .bus_mosi_out    (bus_mosi_out),
    .bus_miso_out    (bus_miso_out),
    .eval            (eval),
    .done_sig        (done_sig),
    .real_mosi_data  (real_mosi_data),
    .real_miso_data  (real_miso_data),
    .fake_mosi_data  (fake_mosi_data),
    .fake_miso_data  (fake_miso_data),
    .fake_mosi_select(fake_mosi_select),
    .fake_miso_select(fake_miso_select),
    .overrun_err     (overrun_err)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  logic [2*DW-1:0] sb_q[$];

  // Scoreboard side: every eval pulse must match the oldest word driven.
  logic            prev_eval = 1'b0;
  logic [2*DW-1:0] sb_e;
  always @(negedge sys_clk) begin
    if (eval) begin
      chk("eval_width", {31'd0, prev_eval}, 32'd0);
      if (!prev_eval) begin
        chk("eval_expected", {31'd0, sb_q.size() > 0}, 32'd1);
        if (sb_q.size() > 0) begin
          sb_e = sb_q.pop_front();
          chk("real_mosi", {24'd0, real_mosi_data}, {24'd0, sb_e[2*DW-1:DW]});
          chk("real_miso", {24'd0, real_miso_data}, {24'd0, sb_e[DW-1:0]});
          chk("eval_latency", cyc - rise_cyc, SS + 1);
        end
      end
    end
    prev_eval = eval;
  end

  // MITM logic model: drops done on eval, answers after mdl_dly cycles.
  bit            mdl_en = 1'b0;
  bit            mdl_echo = 1'b0;
  int            mdl_dly = 3;
  logic [DW-1:0] mdl_word;
  always @(negedge sys_clk) begin
    if (mdl_en && eval) begin
      done_sig = 1'b0;
      mdl_word = real_mosi_data;
      repeat (mdl_dly) @(negedge sys_clk);
      fake_miso_data   = mdl_echo ? mdl_word : 8'h00;
      fake_miso_select = mdl_echo;
      fake_mosi_data   = 8'hFF;
      fake_mosi_select = 1'b0;
      done_sig = 1'b1;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic xfer(input logic [DW-1:0] m, input logic [DW-1:0] s, input int nbits,
                      input logic [DW-1:0] exp_mosi, input logic [DW-1:0] exp_miso);
    if (nbits == DW) sb_q.push_back({m, s});
    for (int i = 0; i < nbits; i++) begin
      bus_mosi_in = m[DW-1-i];
      bus_miso_in = s[DW-1-i];
      wait_cyc(HALF);
      chk("mosi_out_bit", {31'd0, bus_mosi_out}, {31'd0, exp_mosi[DW-1-i]});
      chk("miso_out_bit", {31'd0, bus_miso_out}, {31'd0, exp_miso[DW-1-i]});
      bus_sclk_in = 1'b1;
      if (i == DW - 1) rise_cyc = cyc;
      wait_cyc(HALF);
      bus_sclk_in = 1'b0;
    end
  endtask

  task automatic cs_end();
    wait_cyc(HALF);
    bus_cs_n_in = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);
  endtask

  task automatic drain(input string tag);
    wait_cyc(60);
    chk(tag, sb_q.size(), 0);
  endtask

  initial begin
    fork
      begin
        #1ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset held with live bus traffic
    rst_n = 1'b0;
    bus_cs_n_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_sclk_in = ~bus_sclk_in;
      bus_miso_in = (i % 3) == 0;
      bus_mosi_in = (i % 2) == 0;
      wait_cyc(3);
      chk("rst_miso_fwd", {31'd0, bus_miso_out}, {31'd0, bus_miso_in});
      chk("rst_eval", {31'd0, eval}, 32'd0);
      chk("rst_overrun", {31'd0, overrun_err}, 32'd0);
    end
    chk("rst_real_mosi", {24'd0, real_mosi_data}, 32'd0);
    chk("rst_real_miso", {24'd0, real_miso_data}, 32'd0);
    bus_cs_n_in = 1'b1;
    bus_sclk_in = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);

    // One word with idle logic
    mdl_en = 1'b0;
    bus_cs_n_in = 1'b0;
    xfer(8'hA5, 8'h3C, DW, 8'hA5, 8'h3C);
    cs_end();
    drain("sb_single_word");

    // Echo MOSI onto MISO for the following word
    do_reset();
    mdl_en = 1'b1; mdl_echo = 1'b1; mdl_dly = 3;
    bus_cs_n_in = 1'b0;
    xfer(8'hA5, 8'h3C, DW, 8'hA5, 8'h3C);
    xfer(8'h5A, 8'h00, DW, 8'h5A, 8'hA5);
    cs_end();
    chk("echo_no_overrun", {31'd0, overrun_err}, 32'd0);
    drain("sb_echo");

    // Partial word aborted by CS_N, then a full word
    do_reset();
    bus_cs_n_in = 1'b0;
    xfer(8'hFF, 8'hFF, 5, 8'hFF, 8'hFF);
    cs_end();
    bus_cs_n_in = 1'b0;
    xfer(8'h0F, 8'hF0, DW, 8'h0F, 8'hF0);
    cs_end();
    drain("sb_partial");

    // Logic too slow: overrun and full forwarding of word 2
    do_reset();
    mdl_dly = 40;
    bus_cs_n_in = 1'b0;
    xfer(8'hA5, 8'h3C, DW, 8'hA5, 8'h3C);
    xfer(8'hC3, 8'h96, DW, 8'hC3, 8'h96);
    chk("overrun_set", {31'd0, overrun_err}, 32'd1);
    cs_end();
    drain("sb_overrun");
    chk("overrun_sticky", {31'd0, overrun_err}, 32'd1);

    // Reset in the middle of a replaced word
    do_reset();
    chk("overrun_cleared", {31'd0, overrun_err}, 32'd0);
    mdl_dly = 3;
    bus_cs_n_in = 1'b0;
    xfer(8'hA5, 8'h3C, DW, 8'hA5, 8'h3C);
    xfer(8'h00, 8'h00, 4, 8'h00, 8'hA5);
    bus_miso_in = 1'b1;
    wait_cyc(4);
    chk("pre_rst_replaced", {31'd0, bus_miso_out}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_fwd_now_hi", {31'd0, bus_miso_out}, 32'd1);
    bus_miso_in = 1'b0;
    #1;
    chk("rst_fwd_now_lo", {31'd0, bus_miso_out}, 32'd0);
    wait_cyc(2);
    bus_cs_n_in = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    bus_cs_n_in = 1'b0;
    xfer(8'h3C, 8'hC3, DW, 8'h3C, 8'hC3);
    cs_end();
    drain("sb_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_tap_engine.md
# spi_tap_engine

Bus-side SPI engine for the MITM design. It taps the real SCLK/CS_N/MOSI/MISO lines, deserializes each byte on both data lines, and hands the byte pair to the MITM logic block over the eval/done_sig handshake. It then serializes the returned fake data onto the outgoing MOSI/MISO lines during the following byte, or forwards the real lines unchanged. It sits between the physical pins and the MITM logic: it is the initiator of the handshake that the logic block answers.

## Interface
- DATA_SIZE, 8, bits per SPI word (MSB first)
- SYNC_STAGES, 2, synchronizer flops on every bus input (min 2)

- sys_clk  input  1  system clock; all state is in this domain
- rst_n  input  1  asynchronous, active-low reset
- bus_sclk_in  input  1  real SPI clock; mode 0 (CPOL=0, CPHA=0)
- bus_cs_n_in  input  1  real chip select, active low
- bus_mosi_in  input  1  real MOSI from master
- bus_miso_in  input  1  real MISO from slave
- bus_mosi_out  output  1  MOSI driven to slave
- bus_miso_out  output  1  MISO driven to master
- eval  output  1  one-cycle request to MITM logic; real_*_data valid while high
- done_sig  input  1  MITM logic done/idle level
- real_mosi_data  output  DATA_SIZE  last complete MOSI word
- real_miso_data  output  DATA_SIZE  last complete MISO word
- fake_mosi_data  input  DATA_SIZE  replacement MOSI word
- fake_miso_data  input  DATA_SIZE  replacement MISO word
- fake_mosi_select  input  1  1 = replace MOSI in the next word
- fake_miso_select  input  1  1 = replace MISO in the next word
- overrun_err  output  1  sticky: fake data missed a word boundary

## Operation
- All four bus inputs pass through SYNC_STAGES flops. SCLK rise and fall events are detected on the synchronized SCLK.
- Forwarding is combinational from the raw pins:
  - bus_x_out = sel_x ? tx_x[DATA_SIZE-1] : bus_x_in
  - sel_x is the registered per-word select.
- Receive:
  - Each sync rise with CS_N low shifts synced MOSI and MISO into rx shift registers and increments bit_cnt.
  - At bit_cnt == DATA_SIZE-1 plus a rise:
    - Copy rx into real_*_data.
    - Pulse eval for exactly 1 cycle.
    - Reset bit_cnt to 0.
- Handshake FSM:
  - IDLE: after the eval pulse, go to ACK.
  - ACK: wait for done_sig == 0, then go to BUSY.
  - BUSY: wait for done_sig == 1. Then latch fake_*_data and fake_*_select into pending registers, set pend_valid, and go to IDLE.
- Word boundary event: the first sync fall after a completed word.
  - pend_valid = 1: load tx_x <= pending data, sel_x <= pending select, clear pend_valid.
  - pend_valid = 0: sel_x <= 0. If the handshake FSM is not IDLE, set overrun_err. The late result is discarded when it arrives.
- Within a word, every other sync fall shifts tx_x left by 1.
- The first word after CS_N falls is always forwarded (sel = 0).
- CS_N rising (sync) mid-word or at any time:
  - Clear bit_cnt, rx, sel_x and pend_valid.
  - Do not issue eval.
  - An in-flight handshake completes, but its result is dropped.
- SCLK edges while CS_N is high are ignored.

## Timing
- Reset values:
  - eval = 0, overrun_err = 0, real_*_data = 0.
  - sel_x = 0, tx/rx = 0, bit_cnt = 0, pend_valid = 0, FSM = IDLE.
  - Bus outputs forward their inputs.
- Edge detect latency: SYNC_STAGES+1 sys_clk cycles after the pin edge.
- eval is asserted SYNC_STAGES+1 cycles after the pin rise of the last bit.
- The logic round trip must fit before the boundary fall (half an SCLK period minus sync latency).
  - This requires sys_clk >= 16x SCLK for the standard MITM logic (3-cycle response).
- Replaced bits change SYNC_STAGES+1 cycles after each pin fall. Forwarded bits have no clocked delay.
- overrun_err clears only on rst_n.
- Asynchronous reset mid-word takes effect immediately. Outputs return to forwarding in the same instant.

## Test plan
- Reset: rst_n = 0 with active bus traffic -> eval = 0, overrun_err = 0, bus_miso_out tracks bus_miso_in.
- One word, MOSI = 0xA5, MISO = 0x3C, logic tied idle (done_sig = 1) -> a single 1-cycle eval with real_mosi_data = 0xA5 and real_miso_data = 0x3C. Both outputs are forwarded.
- Two words with a logic model echoing MOSI onto MISO (fake_miso_select = 1, fake_miso_data = 0xA5) -> word 2 bus_miso_out = 1,0,1,0,0,1,0,1, and bus_mosi_out is forwarded.
- CS_N deasserted after 5 bits, then a full word 0x0F -> no eval for the partial word; eval with real_mosi_data = 0x0F after the 8th bit; no replacement.
- done_sig held low past the word-2 boundary fall -> overrun_err = 1, word 2 is fully forwarded, and the late fake data is never output.
- rst_n pulsed low at bit 4 of a replaced word -> bus_miso_out forwards immediately. The next CS_N low session starts at bit 0 with sel = 0.
